// File: rtl/nts_engine_ctrl.sv
// Per-engine packet controller: copies one dispatcher packet into rx memory, runs the parser
// under a watchdog, records a status code and saturating statistics, then releases the packet.
module nts_engine_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 64,
  parameter int MIN_WORDS     = 2,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_areset_n,
  output logic                      o_busy,
  input  logic                      i_dispatch_packet_available,
  output logic                      o_dispatch_packet_read_discard,
  input  logic [DATA_WIDTH/8-1:0]   i_dispatch_data_valid,
  input  logic                      i_dispatch_fifo_empty,
  output logic                      o_dispatch_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     i_dispatch_fifo_rd_data,
  output logic                      o_mem_we,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  output logic                      o_parser_start,
  output logic [ADDR_WIDTH:0]       o_packet_words,
  output logic [DATA_WIDTH/8-1:0]   o_last_word_valid,
  input  logic                      i_parser_done,
  input  logic                      i_parser_error,
  input  logic [TIMEOUT_WIDTH-1:0]  i_timeout,
  output logic [2:0]                o_status,
  output logic [CNT_WIDTH-1:0]      o_cnt_ok,
  output logic [CNT_WIDTH-1:0]      o_cnt_err,
  output logic [2:0]                o_dbg_state
);

  localparam int VW    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD      = 3'd1;
  localparam logic [2:0] ST_OVERFLOW = 3'd2;
  localparam logic [2:0] ST_TIMEOUT  = 3'd3;
  localparam logic [2:0] ST_PERR     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COPY    = 3'd1,
    S_DRAIN   = 3'd2,
    S_PROCESS = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH:0]      words_q, words_d;
  logic                     inflight_q, inflight_d;
  logic                     start_q, start_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [2:0]               status_q, status_d;
  logic [VW-1:0]            mask_q, mask_d;
  logic [CNT_WIDTH-1:0]     cnt_ok_q, cnt_ok_d;
  logic [CNT_WIDTH-1:0]     cnt_err_q, cnt_err_d;

  logic                     rd_en;
  logic                     mem_we;
  logic                     discard;
  logic [ADDR_WIDTH+1:0]    fill;
  logic [TIMEOUT_WIDTH:0]   wd_next;

  // FIFO read has one cycle of latency: a word requested with rd_en is written the next cycle,
  // so the space check counts the outstanding read as already occupying memory.
  assign fill    = {1'b0, words_q} + {{(ADDR_WIDTH+1){1'b0}}, inflight_q};
  assign wd_next = {1'b0, wd_q} + (TIMEOUT_WIDTH+1)'(1);

  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    start_d    = 1'b0;
    wd_d       = wd_q;
    status_d   = status_q;
    mask_d     = mask_q;
    cnt_ok_d   = cnt_ok_q;
    cnt_err_d  = cnt_err_q;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    discard    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
          state_d = S_COPY;
          words_d = '0;
        end
      end
      S_COPY: begin
        rd_en  = !i_dispatch_fifo_empty && (fill < (ADDR_WIDTH+2)'(DEPTH));
        mem_we = inflight_q;
        if (inflight_q) words_d = words_q + (ADDR_WIDTH+1)'(1);
        // Empty here means the last outstanding word is being written this cycle.
        if (i_dispatch_fifo_empty) begin
          mask_d = i_dispatch_data_valid;
          if (words_d < (ADDR_WIDTH+1)'(MIN_WORDS) || i_dispatch_data_valid == '0) begin
            status_d = ST_BAD;
            state_d  = S_DISCARD;
          end else begin
            start_d = 1'b1;
            wd_d    = '0;
            state_d = S_PROCESS;
          end
        end else if (fill == (ADDR_WIDTH+2)'(DEPTH)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_en = !i_dispatch_fifo_empty;
        if (i_dispatch_fifo_empty && !inflight_q) begin
          status_d = ST_OVERFLOW;
          state_d  = S_DISCARD;
        end
      end
      S_PROCESS: begin
        wd_d = wd_next[TIMEOUT_WIDTH-1:0];
        if (i_parser_error) begin
          status_d = ST_PERR;
          state_d  = S_DISCARD;
        end else if (i_parser_done) begin
          status_d = ST_OK;
          state_d  = S_DISCARD;
        end else if (i_timeout != '0 && wd_next == {1'b0, i_timeout}) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DISCARD;
        end
      end
      S_DISCARD: begin
        discard = 1'b1;
        if (status_q == ST_OK) begin
          if (~&cnt_ok_q) cnt_ok_d = cnt_ok_q + CNT_WIDTH'(1);
        end else begin
          if (~&cnt_err_q) cnt_err_d = cnt_err_q + CNT_WIDTH'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inflight_d = rd_en;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= S_IDLE;
      words_q    <= '0;
      inflight_q <= 1'b0;
      start_q    <= 1'b0;
      wd_q       <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      inflight_q <= inflight_d;
      start_q    <= start_d;
      wd_q       <= wd_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign o_busy                         = (state_q != S_IDLE);
  assign o_dispatch_packet_read_discard = discard;
  assign o_dispatch_fifo_rd_en          = rd_en;
  assign o_mem_we                       = mem_we;
  assign o_mem_addr                     = words_q[ADDR_WIDTH-1:0];
  assign o_mem_wdata                    = mem_we ? i_dispatch_fifo_rd_data : '0;
  assign o_parser_start                 = start_q;
  assign o_packet_words                 = words_q;
  assign o_last_word_valid              = mask_q;
  assign o_status                       = status_q;
  assign o_cnt_ok                       = cnt_ok_q;
  assign o_cnt_err                      = cnt_err_q;
  assign o_dbg_state                    = state_q;

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Bench for nts_engine_ctrl: behavioural dispatcher FIFO and parser, memory-write scoreboard,
// table of packet scenarios plus hand-written reset and counter-saturation sequences.
module tb_nts_engine_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int VW = DW / 8;
  localparam int TW = 8;
  localparam int CW = 3;
  localparam int DEPTH = 2 ** AW;
  localparam logic [CW-1:0] CMAX = '1;

  localparam int A_DONE = 0, A_ERR = 1, A_BOTH = 2, A_SILENT = 3;

  logic          clk, rst_n;
  logic          busy, avail, discard, fifo_empty, rd_en, mem_we, pstart, pdone, perr;
  logic [VW-1:0] data_valid, last_valid;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   pkt_words;
  logic [TW-1:0] timeout;
  logic [2:0]    status, dbg_state;
  logic [CW-1:0] cnt_ok, cnt_err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_ok = 0;
  int exp_err = 0;

  // FIFO model: bench tasks own wr_ptr, the read process owns rd_ptr.
  logic [DW-1:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    int            n;
    logic [VW-1:0] mask;
    int            act;
    int            dly;
    logic [TW-1:0] tmo;
    logic [2:0]    st;
  } vec_t;
  vec_t vecs[13];

  nts_engine_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MIN_WORDS(2), .TIMEOUT_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_areset_n(rst_n), .o_busy(busy),
    .i_dispatch_packet_available(avail), .o_dispatch_packet_read_discard(discard),
    .i_dispatch_data_valid(data_valid), .i_dispatch_fifo_empty(fifo_empty),
    .o_dispatch_fifo_rd_en(rd_en), .i_dispatch_fifo_rd_data(rd_data),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_parser_start(pstart), .o_packet_words(pkt_words), .o_last_word_valid(last_valid),
    .i_parser_done(pdone), .i_parser_error(perr), .i_timeout(timeout),
    .o_status(status), .o_cnt_ok(cnt_ok), .o_cnt_err(cnt_err), .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en && wr_ptr != rd_ptr) begin
      rd_data <= fifo_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every memory write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_mem_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        check("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_discard"}, 32'(discard), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_start"}, 32'(pstart), 0);
    check({tag, "_words"}, 32'(pkt_words), 0);
    check({tag, "_last_valid"}, 32'(last_valid), 0);
    check({tag, "_status"}, 32'(status), 0);
    check({tag, "_cnt_ok"}, 32'(cnt_ok), 0);
    check({tag, "_cnt_err"}, 32'(cnt_err), 0);
  endtask

  task automatic load_pkt(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom_range(0, 65535));
      fifo_mem[(wr_ptr + i) % 64] = w;
      if (i < DEPTH) exp_q.push_back({AW'(i), w});
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic run_pkt(input int n, input logic [VW-1:0] mask, input int act, input int dly,
                         input logic [TW-1:0] tmo, input logic [2:0] exp_st);
    int t0, ts, td, nstart, ndisc, exp_lat;
    bit exp_start, finished;
    exp_start = (exp_st != 3'd1) && (exp_st != 3'd2);
    @(negedge clk);
    load_pkt(n);
    data_valid = mask;
    timeout    = tmo;
    avail      = 1'b1;
    t0 = cyc; ts = -1; td = -1; nstart = 0; ndisc = 0; finished = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      pdone = 1'b0;
      perr  = 1'b0;
      if (pstart) begin nstart++; ts = cyc; end
      if (discard) begin ndisc++; if (td < 0) td = cyc; avail = 1'b0; end
      if (ts >= 0 && td < 0 && (cyc - ts) == dly && act != A_SILENT) begin
        pdone = (act == A_DONE) || (act == A_BOTH);
        perr  = (act == A_ERR) || (act == A_BOTH);
      end
      if (td >= 0 && !busy) begin finished = 1; break; end
    end
    avail = 1'b0;
    check("pkt_finished", 32'(finished), 1);
    if (exp_st == 3'd0) begin
      if (exp_ok < int'(CMAX)) exp_ok++;
    end else begin
      if (exp_err < int'(CMAX)) exp_err++;
    end
    check("parser_start_count", 32'(nstart), 32'(exp_start));
    check("discard_count", 32'(ndisc), 1);
    check("status", 32'(status), 32'(exp_st));
    check("packet_words", 32'(pkt_words), 32'((n > DEPTH) ? DEPTH : n));
    if (exp_st != 3'd2) check("last_word_valid", 32'(last_valid), 32'(mask));
    if (exp_start) begin
      check("start_latency", 32'(ts - t0), 32'(n + 2));
      exp_lat = (act == A_SILENT) ? int'(tmo) : dly + 1;
      check("outcome_latency", 32'(td - ts), 32'(exp_lat));
    end
    check("cnt_ok", 32'(cnt_ok), 32'(exp_ok));
    check("cnt_err", 32'(cnt_err), 32'(exp_err));
    check("fifo_left", 32'(wr_ptr - rd_ptr), 0);
    check("sb_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    vecs[0]  = '{4,  2'b11, A_DONE,   5,   8'd0,  3'd0};
    vecs[1]  = '{1,  2'b11, A_DONE,   5,   8'd0,  3'd1};
    vecs[2]  = '{10, 2'b11, A_DONE,   5,   8'd0,  3'd2};
    vecs[3]  = '{4,  2'b11, A_SILENT, 0,   8'd20, 3'd3};
    vecs[4]  = '{3,  2'b11, A_BOTH,   4,   8'd0,  3'd4};
    vecs[5]  = '{5,  2'b10, A_ERR,    2,   8'd0,  3'd4};
    vecs[6]  = '{2,  2'b01, A_DONE,   0,   8'd0,  3'd0};
    vecs[7]  = '{8,  2'b11, A_DONE,   3,   8'd0,  3'd0};
    vecs[8]  = '{9,  2'b11, A_DONE,   3,   8'd0,  3'd2};
    vecs[9]  = '{3,  2'b00, A_DONE,   3,   8'd0,  3'd1};
    vecs[10] = '{6,  2'b11, A_DONE,   19,  8'd20, 3'd0};
    vecs[11] = '{3,  2'b11, A_DONE,   300, 8'd0,  3'd0};
    vecs[12] = '{2,  2'b11, A_SILENT, 0,   8'd1,  3'd3};

    rst_n = 1'b0; avail = 1'b0; pdone = 1'b0; perr = 1'b0;
    timeout = '0; data_valid = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", 32'(dbg_state), 0);

    foreach (vecs[i]) run_pkt(vecs[i].n, vecs[i].mask, vecs[i].act, vecs[i].dly, vecs[i].tmo, vecs[i].st);

    while (exp_ok < int'(CMAX)) run_pkt(2, 2'b11, A_DONE, 1, 8'd0, 3'd0);
    run_pkt(3, 2'b11, A_DONE, 2, 8'd0, 3'd0);
    check("cnt_ok_saturated", 32'(cnt_ok), 32'(CMAX));
    check("cnt_err_saturated", 32'(cnt_err), 32'(CMAX));

    // Asynchronous reset in the middle of a copy.
    @(negedge clk);
    load_pkt(6);
    data_valid = 2'b11;
    avail = 1'b1;
    begin
      bit reached;
      reached = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (exp_q.size() <= 4) begin reached = 1; break; end
      end
      check("mid_copy_reached", 32'(reached), 1);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    avail  = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.delete();
    exp_ok = 0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(4, 2'b11, A_DONE, 5, 8'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
